tmr0_ctrl: RTL and testbench

TMR0_CTRL -- requirements
Module: tmr0_ctrl

---
 rtl/tmr0_if.sv | 30 +++
 rtl/tmr0_ctrl.sv | 171 +++++++++++++++++
 tb/tb_tmr0_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tmr0_if.sv
// Register-access and status bundle for the TMR0 timer block.
// Strobe semantics: opt_we and tmr_we are single-cycle write qualifiers.
// The block samples opt_din or tmr_din on any rising clk edge where the
// matching strobe is high. There is no ready/backpressure, so every strobed
// write is accepted on that edge. t0if_clr is a level sampled on each edge.
interface tmr0_if;
    logic       opt_we;
    logic [7:0] opt_din;
    logic       tmr_we;
    logic [7:0] tmr_din;
    logic       t0cki;
    logic       wdt_tick;
    logic       t0if_clr;
    logic [7:0] tmr0;
    logic [7:0] option_q;
    logic       t0if;
    logic       wdt_out;

    // Side that drives writes and stimulus and observes timer state.
    modport master (
        output opt_we, opt_din, tmr_we, tmr_din, t0cki, wdt_tick, t0if_clr,
        input  tmr0, option_q, t0if, wdt_out
    );

    // The timer block itself.
    modport slave (
        input  opt_we, opt_din, tmr_we, tmr_din, t0cki, wdt_tick, t0if_clr,
        output tmr0, option_q, t0if, wdt_out
    );
endinterface

// File: rtl/tmr0_ctrl.sv
// TMR0 timer/counter with an option register and a shared 8-bit prescaler.
// The count source is either the system clock or a synchronized external
// pin edge. The prescaler serves TMR0 (PSA=0) or the watchdog tick (PSA=1).
// A TMR0 write freezes counting for the two edges that follow the write.
module tmr0_ctrl (
    input  logic  clk,
    input  logic  rst_n,
    tmr0_if.slave bus
);

    // Option register fields.
    logic [7:0] opt_r;
    logic       t0cs;
    logic       t0se;
    logic       psa;
    logic [2:0] ps;

    // Timer state.
    logic [7:0] tmr_r;
    logic [7:0] pre_r;
    logic       t0if_r;
    logic       wdt_r;
    logic [1:0] inh_r;

    // External pin synchronizer plus history flop.
    logic       s1;
    logic       s2;
    logic       s3;

    // Next-state and decode signals.
    logic       pin_rise;
    logic       pin_fall;
    logic       src_tick;
    logic       gated_tick;
    logic [7:0] tmr_ratio_m1;
    logic [7:0] wdt_ratio_m1;
    logic [7:0] pre_next;
    logic       wdt_next;
    logic       tmr_inc;
    logic       overflow;

    assign t0cs = opt_r[5];
    assign t0se = opt_r[4];
    assign psa  = opt_r[3];
    assign ps   = opt_r[2:0];

    assign bus.tmr0     = tmr_r;
    assign bus.option_q = opt_r;
    assign bus.t0if     = t0if_r;
    assign bus.wdt_out  = wdt_r;

    // Pick the count source, apply the write inhibit, and work out how the shared prescaler advances.
    always_comb begin
        pin_rise = s2 & ~s3;
        pin_fall = ~s2 & s3;

        if (!t0cs) begin
            src_tick = 1'b1;
        end else if (t0se) begin
            src_tick = pin_fall;
        end else begin
            src_tick = pin_rise;
        end

        // A nonzero inhibit count drops the tick outright. It is not queued.
        gated_tick = src_tick & (inh_r == 2'd0);

        // Terminal counts: 2^(PS+1)-1 for TMR0 use, 2^PS-1 for watchdog use.
        tmr_ratio_m1 = 8'hFF >> (3'd7 - ps);
        wdt_ratio_m1 = 8'h7F >> (3'd7 - ps);

        pre_next = pre_r;
        wdt_next = 1'b0;
        tmr_inc  = 1'b0;

        if (!psa) begin
            // Prescaler belongs to TMR0. The watchdog tick passes straight through.
            wdt_next = bus.wdt_tick;
            if (gated_tick) begin
                if (pre_r == tmr_ratio_m1) begin
                    pre_next = 8'd0;
                    tmr_inc  = 1'b1;
                end else begin
                    pre_next = pre_r + 8'd1;
                end
            end
        end else begin
            // Prescaler belongs to the watchdog. TMR0 takes every gated tick.
            tmr_inc = gated_tick;
            if (bus.wdt_tick) begin
                if (pre_r == wdt_ratio_m1) begin
                    pre_next = 8'd0;
                    wdt_next = 1'b1;
                end else begin
                    pre_next = pre_r + 8'd1;
                end
            end
        end

        // Option writes always restart the prescaler. TMR0 writes restart it only when it divides TMR0.
        if (bus.opt_we || (bus.tmr_we && !psa)) begin
            pre_next = 8'd0;
        end

        // A TMR0 write on the same edge masks both the increment and the overflow.
        overflow = tmr_inc & (tmr_r == 8'hFF) & ~bus.tmr_we;
    end

    // Bring the asynchronous pin into the clock domain and keep one sample of history for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.t0cki;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Option register. After reset it selects the external pin, falling edge, watchdog prescale /128.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opt_r <= 8'hFF;
        end else if (bus.opt_we) begin
            opt_r <= bus.opt_din;
        end
    end

    // Shared prescaler and the registered watchdog pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_r <= 8'd0;
            wdt_r <= 1'b0;
        end else begin
            pre_r <= pre_next;
            wdt_r <= wdt_next;
        end
    end

    // TMR0 count register and the two-edge inhibit window that follows each write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmr_r <= 8'd0;
            inh_r <= 2'd0;
        end else if (bus.tmr_we) begin
            tmr_r <= bus.tmr_din;
            inh_r <= 2'd2;
        end else begin
            if (tmr_inc) begin
                tmr_r <= tmr_r + 8'd1;
            end
            if (inh_r != 2'd0) begin
                inh_r <= inh_r - 2'd1;
            end
        end
    end

    // Sticky overflow flag. A new overflow takes priority over a clear on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t0if_r <= 1'b0;
        end else if (overflow) begin
            t0if_r <= 1'b1;
        end else if (bus.t0if_clr) begin
            t0if_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tmr0_ctrl.sv
// Self-checking bench for tmr0_ctrl: directed sequences with a behavioural
// reference model compared against the outputs on every falling clock edge.
module tb_tmr0_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    tmr0_if bus ();

    tmr0_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock generation.
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state as the outputs should read after each rising edge.
    logic [7:0] m_opt;
    logic [7:0] m_tmr;
    logic       m_if;
    logic       m_wdt;
    int         m_pre;
    int         n_edge = 0;
    int         w_edge = -10;
    bit         samp[$];     // t0cki as seen at the last three edges, oldest first

    always @(posedge clk) begin : model
        int ps;
        bit psa;
        bit src;
        bit gated;
        bit inc;
        bit ovf;
        bit rise;
        bit fall;
        bit nwdt;
        int npre;
        n_edge++;
        if (!rst_n) begin
            m_opt  = 8'hFF;
            m_tmr  = 8'h00;
            m_if   = 1'b0;
            m_wdt  = 1'b0;
            m_pre  = 0;
            w_edge = -10;
            samp.delete();
            repeat (3) samp.push_back(1'b0);
        end else begin
            ps   = int'(m_opt[2:0]);
            psa  = m_opt[3];
            rise = samp[1] && !samp[0];
            fall = !samp[1] && samp[0];
            if (!m_opt[5]) src = 1'b1;
            else if (m_opt[4]) src = fall;
            else src = rise;
            gated = src && !((n_edge - w_edge) inside {1, 2});
            inc  = 1'b0;
            nwdt = 1'b0;
            npre = m_pre;
            if (!psa) begin
                nwdt = bus.wdt_tick;
                if (gated) begin
                    npre = (m_pre + 1) % (1 << (ps + 1));
                    inc  = (npre == 0);
                end
            end else begin
                inc = gated;
                if (bus.wdt_tick) begin
                    npre = (m_pre + 1) % (1 << ps);
                    nwdt = (npre == 0);
                end
            end
            ovf = inc && (m_tmr == 8'hFF);
            if (bus.tmr_we) begin
                m_tmr  = bus.tmr_din;
                w_edge = n_edge;
                if (!psa) npre = 0;
            end else if (inc) begin
                m_tmr = m_tmr + 8'd1;
            end
            if (ovf && !bus.tmr_we) m_if = 1'b1;
            else if (bus.t0if_clr) m_if = 1'b0;
            if (bus.opt_we) begin
                m_opt = bus.opt_din;
                npre  = 0;
            end
            m_pre = npre;
            m_wdt = nwdt;
            samp.push_back(bus.t0cki);
            void'(samp.pop_front());
        end
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tmr0",     bus.tmr0,     m_tmr);
            chk("option_q", bus.option_q, m_opt);
            chk("t0if",     bus.t0if,     m_if);
            chk("wdt_out",  bus.wdt_out,  m_wdt);
        end
    end

    // Driver tasks: each is entered on a falling edge and returns on the next falling edge.
    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wr_opt(input logic [7:0] v);
        bus.opt_we  = 1'b1;
        bus.opt_din = v;
        @(negedge clk);
        bus.opt_we  = 1'b0;
    endtask

    task automatic wr_tmr(input logic [7:0] v);
        bus.tmr_we  = 1'b1;
        bus.tmr_din = v;
        @(negedge clk);
        bus.tmr_we  = 1'b0;
    endtask

    int wdt_hits[$];

    initial begin
        bus.opt_we   = 1'b0;
        bus.opt_din  = 8'h00;
        bus.tmr_we   = 1'b0;
        bus.tmr_din  = 8'h00;
        bus.t0cki    = 1'b0;
        bus.wdt_tick = 1'b0;
        bus.t0if_clr = 1'b0;
        rst_n        = 1'b0;
        cyc(3);
        chk_en = 1'b1;
        chk("rst_option", bus.option_q, 8'hFF);
        chk("rst_tmr0",   bus.tmr0,     8'h00);
        chk("rst_t0if",   bus.t0if,     1'b0);
        chk("rst_wdt",    bus.wdt_out,  1'b0);
        rst_n = 1'b1;
        cyc(2);

        // Internal clock source, no prescale: a write freezes TMR0 for two edges.
        wr_opt(8'h08);
        wr_tmr(8'h10);
        chk("w30_W",  bus.tmr0, 8'h10);
        cyc(1); chk("w30_W1", bus.tmr0, 8'h10);
        cyc(1); chk("w30_W2", bus.tmr0, 8'h10);
        cyc(1); chk("w30_W3", bus.tmr0, 8'h11);
        cyc(1); chk("w30_W4", bus.tmr0, 8'h12);

        // Prescale /2 into TMR0, overflow from FE.
        wr_opt(8'h00);
        wr_tmr(8'hFE);
        chk("w31_W",  bus.tmr0, 8'hFE);
        cyc(1); chk("w31_W1", bus.tmr0, 8'hFE);
        cyc(1); chk("w31_W2", bus.tmr0, 8'hFE);
        cyc(2); chk("w31_W4", bus.tmr0, 8'hFF);
        cyc(2); chk("w31_W6", bus.tmr0, 8'h00);
        chk("w31_if", bus.t0if, 1'b1);
        bus.t0if_clr = 1'b1; cyc(1); bus.t0if_clr = 1'b0;
        chk("clr_alone", bus.t0if, 1'b0);

        // Clear requested on the same edge as the overflow: the set takes priority.
        wr_tmr(8'hFE);
        cyc(5);
        bus.t0if_clr = 1'b1; cyc(1); bus.t0if_clr = 1'b0;
        chk("clr_ovf_tmr", bus.tmr0, 8'h00);
        chk("clr_ovf_if",  bus.t0if, 1'b1);
        bus.t0if_clr = 1'b1; cyc(1); bus.t0if_clr = 1'b0;
        chk("clr_next", bus.t0if, 1'b0);

        // With the prescaler assigned to TMR0, the watchdog tick passes through unscaled.
        for (int i = 0; i < 3; i++) begin
            bus.wdt_tick = 1'b1; cyc(1); bus.wdt_tick = 1'b0;
            chk("wdt_pass", bus.wdt_out, 1'b1);
            cyc(1);
        end

        // A write on the same edge as an overflow replaces it: no increment, flag untouched.
        wr_opt(8'h08);
        wr_tmr(8'hFF);
        cyc(2); chk("wr_ovf_pre", bus.tmr0, 8'hFF);
        wr_tmr(8'h55);
        chk("wr_ovf_tmr", bus.tmr0, 8'h55);
        chk("wr_ovf_if",  bus.t0if, 1'b0);

        // Option and TMR0 written together, then count falling pin edges only.
        bus.opt_we = 1'b1; bus.opt_din = 8'h38;
        bus.tmr_we = 1'b1; bus.tmr_din = 8'h40;
        cyc(1);
        bus.opt_we = 1'b0; bus.tmr_we = 1'b0;
        chk("both_opt", bus.option_q, 8'h38);
        chk("both_tmr", bus.tmr0,     8'h40);
        cyc(4);
        bus.t0cki = 1'b1;
        cyc(10); chk("pin_rise_ignored", bus.tmr0, 8'h40);
        bus.t0cki = 1'b0;
        cyc(1); chk("pin_fall_e0", bus.tmr0, 8'h40);
        cyc(1); chk("pin_fall_e1", bus.tmr0, 8'h40);
        cyc(1); chk("pin_fall_e2", bus.tmr0, 8'h41);
        cyc(8); chk("pin_settled", bus.tmr0, 8'h41);

        // Watchdog prescale /8: twenty ticks give pulses on the 8th and 16th only.
        wr_opt(8'h0B);
        for (int i = 1; i <= 20; i++) begin
            bus.wdt_tick = 1'b1; cyc(1); bus.wdt_tick = 1'b0;
            if (bus.wdt_out === 1'b1) wdt_hits.push_back(i);
            cyc(1);
        end
        chk("wdt_count", wdt_hits.size(), 2);
        if (wdt_hits.size() == 2) begin
            chk("wdt_first",  wdt_hits[0], 8);
            chk("wdt_second", wdt_hits[1], 16);
        end

        // Reset asserted inside an inhibit window with the flag set.
        wr_tmr(8'hFE);
        cyc(4); chk("pre_rst_if", bus.t0if, 1'b1);
        wr_tmr(8'h80);
        chk("pre_rst_tmr", bus.tmr0, 8'h80);
        rst_n = 1'b0;
        cyc(1);
        chk("rst2_tmr", bus.tmr0,     8'h00);
        chk("rst2_if",  bus.t0if,     1'b0);
        chk("rst2_opt", bus.option_q, 8'hFF);
        rst_n = 1'b1;
        wr_opt(8'h08);
        chk("post_rst_0", bus.tmr0, 8'h00);
        cyc(1); chk("post_rst_1", bus.tmr0, 8'h01);
        cyc(1); chk("post_rst_2", bus.tmr0, 8'h02);
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
